bch_encoder: RTL and testbench

//  Systematic bit-serial BCH encoder, transmit-side counterpart of the chien_search/decoder path.

---
 rtl/bch_encoder_if.sv | 36 +++
 rtl/bch_encoder.sv | 164 ++++++++++++++++
 tb/tb_bch_encoder.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bch_encoder_if.sv
// Handshake bundle for bch_encoder: frame start/code select, message input, codeword output.
// With BCH_ENC_ERR_INJ_EN defined the error-injection controls are added to the bundle.
interface bch_encoder_if;
    logic       i_start;
    logic [1:0] i_code;
    logic       i_valid;
    logic       i_data;
    logic       o_ready;
    logic       o_valid;
    logic       o_data;
    logic       o_last;
    logic       i_ready;
    logic       o_busy;
`ifdef BCH_ENC_ERR_INJ_EN
    logic       i_inj_en;
    logic [9:0] i_inj_pos;

    modport master (
        output i_start, i_code, i_valid, i_data, i_ready, i_inj_en, i_inj_pos,
        input  o_ready, o_valid, o_data, o_last, o_busy
    );
    modport slave (
        input  i_start, i_code, i_valid, i_data, i_ready, i_inj_en, i_inj_pos,
        output o_ready, o_valid, o_data, o_last, o_busy
    );
`else
    modport master (
        output i_start, i_code, i_valid, i_data, i_ready,
        input  o_ready, o_valid, o_data, o_last, o_busy
    );
    modport slave (
        input  i_start, i_code, i_valid, i_data, i_ready,
        output o_ready, o_valid, o_data, o_last, o_busy
    );
`endif
endinterface

// File: rtl/bch_encoder.sv
// Systematic bit-serial BCH encoder for (63,51), (255,239) and (1023,983) codes.
// Optional feature macro: BCH_ENC_ERR_INJ_EN (inverts one selected output bit of a frame).
module bch_encoder #(
    parameter logic [12:0] G63   = 13'h1539,
    parameter logic [16:0] G255  = 17'h16F63,
    parameter logic [40:0] G1023 = 41'h0
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    bch_encoder_if.slave bus
);

    typedef enum logic [1:0] {IDLE, MSG, PAR} state_t;

    localparam logic [1:0] CODE_INVALID = 2'b11;

    state_t      state_q, state_d;
    logic [1:0]  code_q, code_d;
    logic [39:0] lfsr_q, lfsr_d;
    logic [9:0]  cnt_q, cnt_d;
    logic        data_q, data_d;
    logic        valid_q, valid_d;
    logic        last_q, last_d;

    logic [9:0]  k_len, n_len;
    logic [5:0]  r_len;
    logic [39:0] g_low, r_mask;
    logic        lfsr_msb, fb, out_free, flip;

    // The x^r term of g(x) is implicit: it is what shifts out of lfsr[r-1].
    always_comb begin
        case (code_q)
            2'b01: begin
                k_len = 10'd239;
                n_len = 10'd255;
                r_len = 6'd16;
                g_low = {24'b0, G255[15:0]};
            end
            2'b10: begin
                k_len = 10'd983;
                n_len = 10'd1023;
                r_len = 6'd40;
                g_low = G1023[39:0];
            end
            default: begin
                k_len = 10'd51;
                n_len = 10'd63;
                r_len = 6'd12;
                g_low = {28'b0, G63[11:0]};
            end
        endcase
    end

    assign r_mask   = (40'd1 << r_len) - 40'd1;
    assign lfsr_msb = lfsr_q[r_len - 6'd1];
    assign fb       = bus.i_data ^ lfsr_msb;
    assign out_free = !valid_q || bus.i_ready;

    assign bus.o_ready = (state_q == MSG) && out_free;
    assign bus.o_valid = valid_q;
    assign bus.o_data  = data_q;
    assign bus.o_last  = last_q;
    assign bus.o_busy  = (state_q != IDLE);

`ifdef BCH_ENC_ERR_INJ_EN
    logic       inj_en_q, inj_en_d;
    logic [9:0] inj_pos_q, inj_pos_d;

    // cnt_q equals the transmit index of the bit being loaded, so pos >= n never matches.
    assign flip = inj_en_q && (cnt_q == inj_pos_q);
`else
    assign flip = 1'b0;
`endif

    // NOTE: every always_comb target gets its hold value first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        lfsr_d  = lfsr_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
`ifdef BCH_ENC_ERR_INJ_EN
        inj_en_d  = inj_en_q;
        inj_pos_d = inj_pos_q;
`endif
        // An empty or just-consumed output register drops valid unless refilled below.
        if (out_free) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (bus.i_start && (bus.i_code != CODE_INVALID)) begin
                    state_d = MSG;
                    code_d  = bus.i_code;
                    lfsr_d  = '0;
                    cnt_d   = '0;
`ifdef BCH_ENC_ERR_INJ_EN
                    inj_en_d  = bus.i_inj_en;
                    inj_pos_d = bus.i_inj_pos;
`endif
                end
            end
            MSG: begin
                if (bus.i_valid && bus.o_ready) begin
                    data_d  = bus.i_data ^ flip;
                    valid_d = 1'b1;
                    lfsr_d  = ((lfsr_q << 1) ^ (fb ? g_low : 40'd0)) & r_mask;
                    cnt_d   = cnt_q + 10'd1;
                    if (cnt_q == k_len - 10'd1) state_d = PAR;
                end
            end
            PAR: begin
                if (valid_q && last_q && bus.i_ready) begin
                    state_d = IDLE;
                end else if (out_free) begin
                    data_d  = lfsr_msb ^ flip;
                    valid_d = 1'b1;
                    last_d  = (cnt_q == n_len - 10'd1);
                    lfsr_d  = (lfsr_q << 1) & r_mask;
                    cnt_d   = cnt_q + 10'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            code_q  <= 2'b00;
            lfsr_q  <= '0;
            cnt_q   <= '0;
            data_q  <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

`ifdef BCH_ENC_ERR_INJ_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            inj_en_q  <= 1'b0;
            inj_pos_q <= '0;
        end else begin
            inj_en_q  <= inj_en_d;
            inj_pos_q <= inj_pos_d;
        end
    end
`endif

endmodule

// File: tb/tb_bch_encoder.sv
// Self-checking bench for bch_encoder: random frames checked against a polynomial long-division model.
// Define BCH_ENC_ERR_INJ_EN on both RTL and bench to exercise error injection.
module tb_bch_encoder;

    // Test generator for the 1023 code: any degree-40 polynomial exercises the datapath.
    localparam logic [40:0] G1023_TB = 41'h1_23456789AB;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bch_encoder_if bus ();

    bch_encoder #(.G1023(G1023_TB)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;
    bit msg_bits[1023];
    bit exp_bits[1023];
    bit obs_bits[1023];
    int n_obs;

    function automatic void code_dims(input logic [1:0] code, output int n, output int k,
                                      output int r, output logic [40:0] g);
        case (code)
            2'b01:   begin n = 255;  k = 239; r = 16; g = {24'b0, 17'h16F63}; end
            2'b10:   begin n = 1023; k = 983; r = 40; g = G1023_TB;           end
            default: begin n = 63;   k = 51;  r = 12; g = {28'b0, 13'h1539};  end
        endcase
    endfunction

    // mode 0: all zeros, 1: single 1 in the last message bit, 2: random
    task automatic fill_msg(input logic [1:0] code, input int mode);
        int n, k, r;
        logic [40:0] g;
        code_dims(code, n, k, r, g);
        for (int j = 0; j < 1023; j++) msg_bits[j] = 1'b0;
        for (int j = 0; j < k; j++) begin
            if (mode == 2) msg_bits[j] = 1'($urandom);
            else if (mode == 1) msg_bits[j] = (j == k - 1);
        end
    endtask

    // Codeword = m(x)*x^r followed by the remainder of m(x)*x^r divided by g(x).
    task automatic build_expected(input logic [1:0] code);
        int n, k, r;
        logic [40:0] g;
        bit rem[1023];
        code_dims(code, n, k, r, g);
        for (int d = 0; d < n; d++) rem[d] = (d >= r) ? msg_bits[n - 1 - d] : 1'b0;
        for (int d = n - 1; d >= r; d--)
            if (rem[d])
                for (int i = 0; i <= r; i++) rem[d - r + i] ^= g[i];
        for (int j = 0; j < k; j++) exp_bits[j] = msg_bits[j];
        for (int p = 0; p < r; p++) exp_bits[k + p] = rem[r - 1 - p];
    endtask

    task automatic run_frame(input logic [1:0] code, input int rdy_pct, input int vld_pct,
                             input bit check_timing, input bit poke_start, input int abort_at,
                             input bit inj_en, input int inj_pos);
        int n, k, r;
        logic [40:0] g;
        int mi, iter, hold_err, last_err, first_bad;
        bit hold_pend, hold_data, acc_in, acc_out, done;
        code_dims(code, n, k, r, g);
        n_obs = 0; mi = 0; hold_err = 0; last_err = 0; hold_pend = 0; hold_data = 0; done = 0;

        @(negedge clk);
        bus.i_start = 1'b1;
        bus.i_code  = code;
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
`ifdef BCH_ENC_ERR_INJ_EN
        bus.i_inj_en  = inj_en;
        bus.i_inj_pos = 10'(inj_pos);
`endif
        @(negedge clk);
        bus.i_start = 1'b0;
`ifdef BCH_ENC_ERR_INJ_EN
        bus.i_inj_en  = 1'b0;
        bus.i_inj_pos = 10'd0;
`endif
        iter = 1;
        while (!done && iter < 3 * n + 50) begin
            bus.i_ready = ($urandom_range(99) < rdy_pct);
            bus.i_valid = (mi < k) && ($urandom_range(99) < vld_pct);
            bus.i_data  = bus.i_valid ? msg_bits[mi] : 1'($urandom);
            bus.i_start = poke_start && (iter == 10);
            bus.i_code  = poke_start ? ((code == 2'b00) ? 2'b10 : 2'b00) : code;
            #1;
            if (hold_pend && (bus.o_valid !== 1'b1 || bus.o_data !== hold_data)) hold_err++;
            acc_in    = bus.i_valid && bus.o_ready;
            acc_out   = bus.o_valid && bus.i_ready;
            hold_pend = bus.o_valid && !bus.i_ready;
            hold_data = bus.o_data;
            if (acc_out) begin
                obs_bits[n_obs] = bus.o_data;
                if (bus.o_last !== (n_obs == n - 1)) last_err++;
                if (check_timing && n_obs == n - 1) begin
                    checks++;
                    if (iter != n + 1) begin
                        errors++;
                        $display("FAIL latency: o_last at cycle %0d after start, expected %0d", iter, n + 1);
                    end
                end
                n_obs++;
                if (n_obs == n || n_obs == abort_at) done = 1;
            end
            @(posedge clk);
            if (acc_in) mi++;
            @(negedge clk);
            iter++;
        end
        bus.i_start = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        if (abort_at >= 0) return;

        #1;
        checks++;
        if (n_obs != n) begin
            errors++;
            $display("FAIL frame_len code=%0d: got %0d bits, expected %0d (timeout)", code, n_obs, n);
        end
        checks++;
        if (mi != k) begin
            errors++;
            $display("FAIL msg_accept code=%0d: accepted %0d bits, expected %0d", code, mi, k);
        end
        checks++;
        if (bus.o_busy !== 1'b0 || bus.o_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_after code=%0d: busy=%b valid=%b, expected 0 0", code, bus.o_busy, bus.o_valid);
        end
        checks++;
        if (hold_err != 0) begin
            errors++;
            $display("FAIL hold code=%0d: %0d stall cycles changed output, expected 0", code, hold_err);
        end
        checks++;
        if (last_err != 0) begin
            errors++;
            $display("FAIL o_last code=%0d: %0d misplaced o_last, expected 0", code, last_err);
        end
        if (inj_en && inj_pos < n) exp_bits[inj_pos] = ~exp_bits[inj_pos];
        first_bad = -1;
        for (int j = n - 1; j >= 0; j--)
            if (j < n_obs && obs_bits[j] !== exp_bits[j]) first_bad = j;
        checks++;
        if (first_bad >= 0) begin
            errors++;
            $display("FAIL codeword code=%0d: bit %0d is %b, expected %b", code, first_bad,
                     obs_bits[first_bad], exp_bits[first_bad]);
        end
    endtask

    task automatic check_parity_const(input string name, input int k, input int r,
                                      input logic [39:0] expected);
        logic [39:0] par;
        par = '0;
        for (int p = 0; p < r; p++) par[r - 1 - p] = obs_bits[k + p];
        checks++;
        if (par !== expected) begin
            errors++;
            $display("FAIL %s: parity %h, expected %h", name, par, expected);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({bus.o_valid, bus.o_data, bus.o_last, bus.o_ready, bus.o_busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset: outputs %b, expected 00000",
                     {bus.o_valid, bus.o_data, bus.o_last, bus.o_ready, bus.o_busy});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_zero_63();
        int ones;
        fill_msg(2'b00, 0);
        build_expected(2'b00);
        run_frame(2'b00, 100, 100, 1'b1, 1'b0, -1, 1'b0, 0);
        ones = 0;
        for (int j = 0; j < 63; j++) if (obs_bits[j] !== 1'b0) ones++;
        checks++;
        if (ones != 0) begin
            errors++;
            $display("FAIL zero_63: %0d nonzero bits, expected 0", ones);
        end
    endtask

    task automatic test_impulse();
        fill_msg(2'b00, 1);
        build_expected(2'b00);
        run_frame(2'b00, 100, 100, 1'b1, 1'b0, -1, 1'b0, 0);
        check_parity_const("impulse_63", 51, 12, 40'h539);
        checks++;
        if (obs_bits[50] !== 1'b1) begin
            errors++;
            $display("FAIL impulse_63_msb: bit 50 is %b, expected 1", obs_bits[50]);
        end
        fill_msg(2'b01, 1);
        build_expected(2'b01);
        run_frame(2'b01, 100, 100, 1'b1, 1'b0, -1, 1'b0, 0);
        check_parity_const("impulse_255", 239, 16, 40'h6F63);
    endtask

    task automatic test_random();
        for (int c = 0; c < 3; c++) begin
            fill_msg(2'(c), 2);
            build_expected(2'(c));
            run_frame(2'(c), 60, 75, 1'b0, 1'b0, -1, 1'b0, 0);
        end
        fill_msg(2'b10, 2);
        build_expected(2'b10);
        run_frame(2'b10, 100, 100, 1'b1, 1'b0, -1, 1'b0, 0);
    endtask

    task automatic test_invalid_code();
        int bad;
        bad = 0;
        @(negedge clk);
        bus.i_start = 1'b1;
        bus.i_code  = 2'b11;
        bus.i_valid = 1'b1;
        bus.i_data  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (bus.o_busy !== 1'b0 || bus.o_valid !== 1'b0 || bus.o_ready !== 1'b0) bad++;
            @(negedge clk);
            bus.i_start = 1'b0;
        end
        bus.i_valid = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL invalid_code: %0d cycles with busy/valid/ready set, expected 0", bad);
        end
    endtask

    task automatic test_reset_mid_frame();
        fill_msg(2'b00, 2);
        build_expected(2'b00);
        run_frame(2'b00, 100, 100, 1'b0, 1'b0, 56, 1'b0, 0);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.o_valid, bus.o_data, bus.o_last, bus.o_ready, bus.o_busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset_mid_frame: outputs %b, expected 00000",
                     {bus.o_valid, bus.o_data, bus.o_last, bus.o_ready, bus.o_busy});
        end
        @(negedge clk);
        rst_n = 1'b1;
        fill_msg(2'b01, 2);
        build_expected(2'b01);
        run_frame(2'b01, 80, 90, 1'b0, 1'b0, -1, 1'b0, 0);
    endtask

    task automatic test_back_to_back();
        fill_msg(2'b01, 2);
        build_expected(2'b01);
        run_frame(2'b01, 100, 100, 1'b1, 1'b1, -1, 1'b0, 0);
        fill_msg(2'b00, 2);
        build_expected(2'b00);
        run_frame(2'b00, 100, 100, 1'b1, 1'b1, -1, 1'b0, 0);
    endtask

`ifdef BCH_ENC_ERR_INJ_EN
    task automatic test_err_inj();
        fill_msg(2'b00, 2);
        build_expected(2'b00);
        run_frame(2'b00, 70, 80, 1'b0, 1'b0, -1, 1'b1, 3);
        fill_msg(2'b00, 2);
        build_expected(2'b00);
        run_frame(2'b00, 100, 100, 1'b0, 1'b0, -1, 1'b1, 70);
        fill_msg(2'b01, 2);
        build_expected(2'b01);
        run_frame(2'b01, 100, 100, 1'b0, 1'b0, -1, 1'b1, 250);
    endtask
`endif

    initial begin
        bus.i_start = 1'b0;
        bus.i_code  = 2'b00;
        bus.i_valid = 1'b0;
        bus.i_data  = 1'b0;
        bus.i_ready = 1'b1;
`ifdef BCH_ENC_ERR_INJ_EN
        bus.i_inj_en  = 1'b0;
        bus.i_inj_pos = 10'd0;
`endif
        test_reset();
        test_zero_63();
        test_impulse();
        test_random();
        test_invalid_code();
        test_reset_mid_frame();
        test_back_to_back();
`ifdef BCH_ENC_ERR_INJ_EN
        test_err_inj();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
